// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit instructions from a byte-wide memory port.
// Define ICACHE_EN to add a 128-entry direct-mapped instruction cache.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_or_not,
    input  logic [31:0] jump_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [2:0]  r_issue;
    logic [1:0]  r_recv;
    logic        r_gnt;
    logic [23:0] r_buf;
    logic        w_fresh;
    logic        w_hit;
    logic [31:0] w_cdata;

    assign w_fresh = (r_state == FETCH) && (r_issue == 3'd0)
                     && (r_recv == 2'd0) && !r_gnt;

`ifdef ICACHE_EN
    logic [127:0] r_cvalid;
    logic [8:0]   r_ctag  [128];
    logic [31:0]  r_cdata [128];
    logic [6:0]   w_idx;
    logic [8:0]   w_tag;
    logic         w_fill;

    assign w_idx   = r_pc[8:2];
    assign w_tag   = r_pc[17:9];
    assign w_hit   = w_fresh && r_cvalid[w_idx] && (r_ctag[w_idx] == w_tag);
    assign w_cdata = r_cdata[w_idx];
    // Only a fill that completes without a redirect may update the entry.
    assign w_fill  = (r_state == FETCH) && !jump_or_not
                     && r_gnt && (r_recv == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cvalid <= '0;
        else if (w_fill) r_cvalid[w_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_ctag[w_idx]  <= w_tag;
            r_cdata[w_idx] <= {mem_din, r_buf};
        end
    end
`else
    assign w_hit   = 1'b0;
    assign w_cdata = 32'd0;
`endif

    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_addr = 32'd0;
        unique case (r_state)
            IDLE: w_next = FETCH;
            FETCH: begin
                if (w_hit) begin
                    w_next = HOLD;
                end else begin
                    if (r_issue < 3'd4) begin
                        mem_req  = 1'b1;
                        mem_addr = r_pc + {29'd0, r_issue};
                    end
                    if (r_gnt && (r_recv == 2'd3)) w_next = HOLD;
                end
            end
            HOLD: if (!stall_i) w_next = FETCH;
            default: w_next = IDLE;
        endcase
        if (jump_or_not) w_next = FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= 32'd0;
            r_issue    <= 3'd0;
            r_recv     <= 2'd0;
            r_gnt      <= 1'b0;
            r_buf      <= 24'd0;
            pc_o       <= 32'd0;
            inst_o     <= 32'd0;
            inst_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (jump_or_not) begin
                // Dropping r_gnt discards any byte still in flight.
                r_pc       <= jump_addr;
                r_issue    <= 3'd0;
                r_recv     <= 2'd0;
                r_gnt      <= 1'b0;
                inst_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_issue <= 3'd0;
                        r_recv  <= 2'd0;
                        r_gnt   <= 1'b0;
                    end
                    FETCH: begin
                        if (w_hit) begin
                            inst_o     <= w_cdata;
                            pc_o       <= r_pc;
                            inst_valid <= 1'b1;
                        end else begin
                            r_gnt <= mem_req & mem_gnt;
                            if (mem_req && mem_gnt) r_issue <= r_issue + 3'd1;
                            if (r_gnt) begin
                                if (r_recv == 2'd3) begin
                                    inst_o     <= {mem_din, r_buf};
                                    pc_o       <= r_pc;
                                    inst_valid <= 1'b1;
                                    r_recv     <= 2'd0;
                                end else begin
                                    r_buf[{r_recv, 3'b000} +: 8] <= mem_din;
                                    r_recv <= r_recv + 2'd1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            r_pc       <= r_pc + 32'd4;
                            r_issue    <= 3'd0;
                            r_recv     <= 2'd0;
                            r_gnt      <= 1'b0;
                            inst_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory model plus a scoreboard of expected
// (pc, instruction) pairs popped whenever inst_valid is observed.
module tb_if_fetch;
    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_or_not;
    logic [31:0] jump_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_din;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb[$];

    if_fetch dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .jump_or_not(jump_or_not), .jump_addr(jump_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_din(mem_din), .pc_o(pc_o), .inst_o(inst_o),
        .inst_valid(inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] boot;
        boot = 32'h00100513;
        if (a < 32'd4) return boot[{a[1:0], 3'b000} +: 8];
        return (a[7:0] * 8'd3) ^ a[19:12] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mbyte(a + 32'd3), mbyte(a + 32'd2),
                mbyte(a + 32'd1), mbyte(a)};
    endfunction

    // Memory: a request granted in one cycle returns its byte the next.
    logic        pend;
    logic [31:0] paddr;
    initial begin pend = 1'b0; paddr = 32'd0; mem_din = 8'd0; end
    always @(negedge clk) begin
        pend  = mem_req && mem_gnt;
        paddr = mem_addr;
    end
    always @(posedge clk) mem_din <= pend ? mbyte(paddr) : 8'h00;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; stall_i = 1'b1; jump_or_not = 1'b0;
        jump_addr = 32'd0; mem_gnt = 1'b1;
        tick; tick; smp;
        checks++;
        if (mem_req !== 1'b0) begin errors++;
            $display("FAIL rst_req: got %0h want 0", mem_req); end
        checks++;
        if (mem_addr !== 32'd0) begin errors++;
            $display("FAIL rst_addr: got %0h want 0", mem_addr); end
        checks++;
        if (pc_o !== 32'd0) begin errors++;
            $display("FAIL rst_pc: got %0h want 0", pc_o); end
        checks++;
        if (inst_o !== 32'd0) begin errors++;
            $display("FAIL rst_inst: got %0h want 0", inst_o); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid: got %0h want 0", inst_valid); end
        tick;
    endtask

    task automatic test_basic;
        exp_t e;
        rst = 1'b0;
        sb.push_back('{pc: 32'd0, inst: 32'h00100513});
        for (int c = 0; c <= 6; c++) begin
            smp;
            if (c == 0) begin
                checks++;
                if (mem_req !== 1'b0) begin errors++;
                    $display("FAIL idle_req: got %0h want 0", mem_req); end
            end else if (c <= 4) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, 32'(c - 1)}) begin errors++;
                    $display("FAIL basic_req c%0d: got %0h/%0h want 1/%0h",
                             c, mem_req, mem_addr, c - 1); end
            end else if (c == 5) begin
                checks++;
                if (inst_valid !== 1'b0) begin errors++;
                    $display("FAIL basic_early_valid: got %0h want 0", inst_valid); end
            end else begin
                checks++;
                if (inst_valid !== 1'b1) begin errors++;
                    $display("FAIL basic_valid: got %0h want 1", inst_valid);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (inst_o !== e.inst) begin errors++;
                        $display("FAIL basic_inst: got %h want %h", inst_o, e.inst); end
                    checks++;
                    if (pc_o !== e.pc) begin errors++;
                        $display("FAIL basic_pc: got %h want %h", pc_o, e.pc); end
                end
            end
            tick;
        end
    endtask

    task automatic test_gap;
        exp_t e;
        sb.push_back('{pc: 32'd4, inst: word(32'd4)});
        for (int c = 0; c <= 8; c++) begin
            stall_i = (c == 0) ? 1'b0 : 1'b1;
            mem_gnt = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            smp;
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, 32'd6}) begin errors++;
                    $display("FAIL gap_addr c%0d: got %0h/%0h want 1/6",
                             c, mem_req, mem_addr); end
            end
            if (c == 7) begin
                checks++;
                if (inst_valid !== 1'b0) begin errors++;
                    $display("FAIL gap_early_valid: got %0h want 0", inst_valid); end
            end
            if (c == 8) begin
                checks++;
                if (inst_valid !== 1'b1) begin errors++;
                    $display("FAIL gap_valid: got %0h want 1", inst_valid);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({pc_o, inst_o} !== {e.pc, e.inst}) begin errors++;
                        $display("FAIL gap_inst: got %h/%h want %h/%h",
                                 pc_o, inst_o, e.pc, e.inst); end
                end
            end
            tick;
        end
    endtask

    task automatic test_stall;
        stall_i = 1'b1; mem_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            smp;
            checks++;
            if ({pc_o, inst_o, mem_req, inst_valid}
                !== {32'd4, word(32'd4), 1'b0, 1'b1}) begin errors++;
                $display("FAIL stall_hold c%0d: got %h/%h/%0h/%0h want 4/%h/0/1",
                         c, pc_o, inst_o, mem_req, inst_valid, word(32'd4)); end
            tick;
        end
        stall_i = 1'b0;
        smp;
        tick;
        stall_i = 1'b1;
        smp;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'd8}) begin errors++;
            $display("FAIL stall_release: got %0h/%h want 1/8", mem_req, mem_addr); end
        tick;
    endtask

    task automatic test_jump;
        exp_t e;
        int   n;
        smp;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'd9}) begin errors++;
            $display("FAIL jump_pre: got %0h/%h want 1/9", mem_req, mem_addr); end
        tick;
        jump_or_not = 1'b1; jump_addr = 32'h1000; stall_i = 1'b1;
        sb.push_back('{pc: 32'h1000, inst: word(32'h1000)});
        tick;
        jump_or_not = 1'b0;
        smp;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h1000}) begin errors++;
            $display("FAIL jump_addr: got %0h/%h want 1/1000", mem_req, mem_addr); end
        n = 0;
        while (!inst_valid && n < 20) begin tick; smp; n++; end
        checks++;
        if (inst_valid !== 1'b1) begin errors++;
            $display("FAIL jump_timeout: got %0h want 1", inst_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if ({pc_o, inst_o} !== {e.pc, e.inst}) begin errors++;
                $display("FAIL jump_inst: got %h/%h want %h/%h",
                         pc_o, inst_o, e.pc, e.inst); end
            checks++;
            if (n !== 5) begin errors++;
                $display("FAIL jump_latency: got %0d want 5", n); end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   got;
        jump_or_not = 1'b1; jump_addr = 32'hFFFF_FFF8; stall_i = 1'b0;
        sb.push_back('{pc: 32'hFFFF_FFF8, inst: word(32'hFFFF_FFF8)});
        sb.push_back('{pc: 32'hFFFF_FFFC, inst: word(32'hFFFF_FFFC)});
        sb.push_back('{pc: 32'h0, inst: 32'h00100513});
        sb.push_back('{pc: 32'h4, inst: word(32'h4)});
        tick;
        jump_or_not = 1'b0;
        got = 0;
        for (int n = 0; n < 300 && got < 4; n++) begin
            mem_gnt = 1'($urandom_range(0, 1));
            smp;
            if (inst_valid) begin
                e = sb.pop_front();
                got++;
                checks++;
                if ({pc_o, inst_o} !== {e.pc, e.inst}) begin errors++;
                    $display("FAIL b2b_inst%0d: got %h/%h want %h/%h",
                             got, pc_o, inst_o, e.pc, e.inst); end
            end
            tick;
        end
        stall_i = 1'b1; mem_gnt = 1'b1;
        checks++;
        if (got !== 4) begin errors++;
            $display("FAIL b2b_timeout: got %0d want 4", got);
            sb.delete();
        end
    endtask

`ifdef ICACHE_EN
    task automatic test_cache;
        exp_t e;
        int   cnt;
        jump_or_not = 1'b1; jump_addr = 32'h40;
        sb.push_back('{pc: 32'h40, inst: word(32'h40)});
        tick;
        jump_or_not = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            smp;
            if (mem_req) cnt++;
            if (inst_valid) break;
            tick;
        end
        e = sb.pop_front();
        checks++;
        if ({inst_valid, pc_o, inst_o} !== {1'b1, e.pc, e.inst}) begin errors++;
            $display("FAIL cache_fill: got %0h/%h/%h want 1/%h/%h",
                     inst_valid, pc_o, inst_o, e.pc, e.inst); end
        checks++;
        if (cnt !== 4) begin errors++;
            $display("FAIL cache_miss_reqs: got %0d want 4", cnt); end
        tick;
        jump_or_not = 1'b1;
        sb.push_back('{pc: 32'h40, inst: word(32'h40)});
        tick;
        jump_or_not = 1'b0;
        smp;
        checks++;
        if (mem_req !== 1'b0) begin errors++;
            $display("FAIL cache_hit_req: got %0h want 0", mem_req); end
        tick;
        smp;
        e = sb.pop_front();
        checks++;
        if ({inst_valid, pc_o, inst_o} !== {1'b1, e.pc, e.inst}) begin errors++;
            $display("FAIL cache_hit: got %0h/%h/%h want 1/%h/%h",
                     inst_valid, pc_o, inst_o, e.pc, e.inst); end
        tick;
    endtask
`endif

    task automatic test_reset_mid;
        exp_t e;
        int   n;
        jump_or_not = 1'b1; jump_addr = 32'h80; stall_i = 1'b1; mem_gnt = 1'b1;
        tick;
        jump_or_not = 1'b0;
        tick; tick;
        rst = 1'b1;
        smp;
        checks++;
        if ({mem_req, mem_addr, pc_o, inst_o, inst_valid} !== 98'd0) begin
            errors++;
            $display("FAIL midrst_zero: got %0h/%h/%h/%h/%0h want all 0",
                     mem_req, mem_addr, pc_o, inst_o, inst_valid); end
        tick;
        rst = 1'b0;
        sb.push_back('{pc: 32'd0, inst: 32'h00100513});
        smp;
        tick;
        smp;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'd0}) begin errors++;
            $display("FAIL midrst_refetch: got %0h/%h want 1/0", mem_req, mem_addr); end
        n = 0;
        while (!inst_valid && n < 20) begin tick; smp; n++; end
        checks++;
        if (inst_valid !== 1'b1) begin errors++;
            $display("FAIL midrst_timeout: got %0h want 1", inst_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if ({pc_o, inst_o} !== {e.pc, e.inst}) begin errors++;
                $display("FAIL midrst_inst: got %h/%h want %h/%h",
                         pc_o, inst_o, e.pc, e.inst); end
        end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_gap;
        test_stall;
        test_jump;
        test_back_to_back;
`ifdef ICACHE_EN
        test_cache;
`endif
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
